// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: response port tags, the default data width and
// the width helper for the outstanding-tag counter.
package cpu_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/resp_demux_if.sv
// Bus bundle between the request/response side and the two response ports.
// slave = the demultiplexer's view, master = the environment driving it.
interface resp_demux_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = 4
);

   logic                          req_fire;
   logic                          req_sel;
   logic                          req_ready;
   logic                          rsp_valid;
   logic [WIDTH-1:0]              rsp_data;
   logic                          rsp_ready;
   logic                          out0_valid;
   logic [WIDTH-1:0]              out0_data;
   logic                          out0_ready;
   logic                          out1_valid;
   logic [WIDTH-1:0]              out1_data;
   logic                          out1_ready;
   logic [count_width(DEPTH)-1:0] outstanding;
   logic                          err_orphan;

   modport slave (
      input  req_fire, req_sel, rsp_valid, rsp_data, out0_ready, out1_ready,
      output req_ready, rsp_ready, out0_valid, out0_data, out1_valid, out1_data,
             outstanding, err_orphan
   );

   modport master (
      output req_fire, req_sel, rsp_valid, rsp_data, out0_ready, out1_ready,
      input  req_ready, rsp_ready, out0_valid, out0_data, out1_valid, out1_data,
             outstanding, err_orphan
   );

endinterface

// File: rtl/tag_fifo.sv
// Order FIFO of 1-bit port tags. DEPTH must be a power of two so the
// pointers wrap by plain overflow.
module tag_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          tag_in,
   input  logic                          pop,
   output logic                          tag_out,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only legal when the head leaves this cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: the tag storage is deliberately not reset; count qualifies every
   // read, so stale entries are never observed and reset fan-out stays small.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= tag_in;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge values of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign tag_out = mem[rd_ptr];
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);

endmodule

// File: rtl/resp_demux.sv
// Routes in-order memory responses to the instruction or data port using the
// tag FIFO head. Define RESP_DEMUX_OUTREG_EN for a registered output stage.
module resp_demux
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   resp_demux_if.slave   bus
);

   localparam int CW = count_width(DEPTH);

   logic             fifo_full;
   logic             fifo_empty;
   logic             head_tag;
   logic [CW-1:0]    fifo_count;
   logic             push;
   logic             pop;
   logic             orphan;
   logic             sel_ready;
   logic             rsp_ready;
   logic             req_ready;
   logic [WIDTH-1:0] payload;

   assign payload   = bus.rsp_data;
   assign orphan    = bus.rsp_valid && fifo_empty;
   // Orphans are always swallowed; otherwise the targeted port decides.
   assign rsp_ready = !reset && (fifo_empty ? bus.rsp_valid : sel_ready);
   assign pop       = bus.rsp_valid && rsp_ready && !fifo_empty;
   assign req_ready = !fifo_full || pop;
   assign push      = bus.req_fire && req_ready;

   tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .tag_in  (bus.req_sel),
      .pop     (pop),
      .tag_out (head_tag),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

`ifdef RESP_DEMUX_OUTREG_EN
   logic             reg0_valid;
   logic             reg1_valid;
   logic [WIDTH-1:0] reg0_data;
   logic [WIDTH-1:0] reg1_data;
   logic             load0;
   logic             load1;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      sel_ready = 1'b0;
      load0     = 1'b0;
      load1     = 1'b0;
      if (head_tag == PORT_DATA) begin
         sel_ready = !reg1_valid || bus.out1_ready;
         load1     = pop;
      end else begin
         sel_ready = !reg0_valid || bus.out0_ready;
         load0     = pop;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg0_valid <= 1'b0;
         reg1_valid <= 1'b0;
      end else begin
         if (load0)               reg0_valid <= 1'b1;
         else if (bus.out0_ready) reg0_valid <= 1'b0;
         if (load1)               reg1_valid <= 1'b1;
         else if (bus.out1_ready) reg1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (load0) reg0_data <= payload;
      if (load1) reg1_data <= payload;
   end

   assign bus.out0_valid = reg0_valid;
   assign bus.out0_data  = reg0_data;
   assign bus.out1_valid = reg1_valid;
   assign bus.out1_data  = reg1_data;
`else
   logic route0;
   logic route1;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      sel_ready = 1'b0;
      route0    = 1'b0;
      route1    = 1'b0;
      if (bus.rsp_valid && !fifo_empty) begin
         if (head_tag == PORT_DATA) route1 = 1'b1;
         else                       route0 = 1'b1;
      end
      if (head_tag == PORT_DATA) sel_ready = bus.out1_ready;
      else                       sel_ready = bus.out0_ready;
   end

   assign bus.out0_valid = route0;
   assign bus.out0_data  = payload;
   assign bus.out1_valid = route1;
   assign bus.out1_data  = payload;
`endif

   // Sticky until reset so software can observe a lost-tag event later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       bus.err_orphan <= 1'b0;
      else if (orphan) bus.err_orphan <= 1'b1;
   end

   assign bus.req_ready   = req_ready;
   assign bus.rsp_ready   = rsp_ready;
   assign bus.outstanding = fifo_count;

endmodule

// File: tb/tb_resp_demux.sv
// Scoreboard bench for resp_demux: per-port expected-data queues filled at
// stimulus time, drained by a monitor that compares on every output handshake.
module tb_resp_demux;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
`ifdef RESP_DEMUX_OUTREG_EN
   localparam bit OUTREG = 1'b1;
`else
   localparam bit OUTREG = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   resp_demux_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   resp_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int               n_checks = 0;
   int               n_errors = 0;
   logic [WIDTH-1:0] exp0[$];
   logic [WIDTH-1:0] exp1[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: any valid with nothing expected is spurious; a handshake pops.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out0_valid) begin
            if (exp0.size() == 0)    check("out0 spurious valid", bus.out0_valid, 1'b0);
            else if (bus.out0_ready) check("out0 data", bus.out0_data, exp0.pop_front());
         end
         if (bus.out1_valid) begin
            if (exp1.size() == 0)    check("out1 spurious valid", bus.out1_valid, 1'b0);
            else if (bus.out1_ready) check("out1 data", bus.out1_data, exp1.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1, "simulation timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tag(input logic tag);
      bus.req_fire = 1'b1;
      bus.req_sel  = tag;
      step();
      bus.req_fire = 1'b0;
   endtask

   task automatic send_rsp(input logic port, input logic [WIDTH-1:0] d);
      bit ok;
      ok = 1'b0;
      if (port) exp1.push_back(d);
      else      exp0.push_back(d);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("rsp accepted within budget", ok, 1'b1);
      step();
      bus.rsp_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " outstanding"}, bus.outstanding, 0);
      check({tag, " req_ready"},   bus.req_ready, 1);
      check({tag, " rsp_ready"},   bus.rsp_ready, 0);
      check({tag, " out0_valid"},  bus.out0_valid, 0);
      check({tag, " out1_valid"},  bus.out1_valid, 0);
      check({tag, " err_orphan"},  bus.err_orphan, 0);
   endtask

   initial begin
      bus.req_fire   = 1'b0;
      bus.req_sel    = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_data   = '0;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      #2;
      check_reset_values("por");
      step();
      reset = 1'b0;
      step();

      // In-order routing of three responses across both ports.
      push_tag(1'b0);
      push_tag(1'b1);
      push_tag(1'b0);
      check("three tags outstanding", bus.outstanding, 3);
      exp0.push_back(32'hA);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hA;
      @(negedge clk);
      check("first rsp out0_valid same cycle", bus.out0_valid, !OUTREG);
      check("first rsp out1_valid same cycle", bus.out1_valid, 0);
      check("first rsp rsp_ready", bus.rsp_ready, 1);
      step();
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      check("first rsp out0_valid next cycle", bus.out0_valid, OUTREG);
      step();
      send_rsp(1'b1, 32'hB);
      send_rsp(1'b0, 32'hC);
      repeat (3) step();
      check("ordered drain outstanding", bus.outstanding, 0);

      // Full FIFO, ignored illegal push, then simultaneous pop and push.
      push_tag(1'b1);
      push_tag(1'b0);
      push_tag(1'b0);
      push_tag(1'b1);
      bus.req_fire = 1'b1;
      bus.req_sel  = 1'b0;
      @(negedge clk);
      check("full req_ready", bus.req_ready, 0);
      check("full outstanding", bus.outstanding, 4);
      step();
      bus.req_fire = 1'b0;
      @(negedge clk);
      check("push while full ignored", bus.outstanding, 4);
      step();
      exp1.push_back(32'h11);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h11;
      bus.req_fire  = 1'b1;
      bus.req_sel   = 1'b0;
      @(negedge clk);
      check("full with pop req_ready", bus.req_ready, 1);
      check("full with pop rsp_ready", bus.rsp_ready, 1);
      step();
      bus.rsp_valid = 1'b0;
      bus.req_fire  = 1'b0;
      @(negedge clk);
      check("pop+push outstanding", bus.outstanding, 4);
      step();
      send_rsp(1'b0, 32'h21);
      send_rsp(1'b0, 32'h22);
      send_rsp(1'b1, 32'h23);
      send_rsp(1'b0, 32'h24);
      repeat (3) step();
      check("wrap drain outstanding", bus.outstanding, 0);

      // Orphan response with an empty FIFO.
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hDEAD;
      @(negedge clk);
      check("orphan rsp_ready", bus.rsp_ready, 1);
      check("orphan out0_valid", bus.out0_valid, 0);
      check("orphan out1_valid", bus.out1_valid, 0);
      check("orphan flag not yet", bus.err_orphan, 0);
      step();
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      check("orphan flag set", bus.err_orphan, 1);
      repeat (3) step();
      check("orphan flag sticky", bus.err_orphan, 1);
      reset = 1'b1;
      #1;
      check("reset clears orphan flag", bus.err_orphan, 0);
      step();
      reset = 1'b0;
      step();

      // Backpressure on the data port holds valid and data.
      push_tag(1'b1);
      exp1.push_back(32'h55);
      bus.out1_ready = 1'b0;
      bus.rsp_valid  = 1'b1;
      bus.rsp_data   = 32'h55;
      if (OUTREG) begin
         @(negedge clk);
         check("outreg accepts into register", bus.rsp_ready, 1);
         step();
         bus.rsp_valid = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall out1_valid", bus.out1_valid, 1);
         check("stall out1_data", bus.out1_data, 32'h55);
         check("stall out0_valid", bus.out0_valid, 0);
         check("stall rsp_ready", bus.rsp_ready, 0);
         check("stall outstanding", bus.outstanding, OUTREG ? 0 : 1);
         step();
      end
      bus.out1_ready = 1'b1;
      @(negedge clk);
      check("stall release out1_valid", bus.out1_valid, 1);
      step();
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      check("stall drained outstanding", bus.outstanding, 0);
      check("stall drained out1_valid", bus.out1_valid, 0);
      step();

      // Asynchronous reset with two tags outstanding, then a late response.
      push_tag(1'b0);
      push_tag(1'b1);
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      bus.rsp_valid  = 1'b1;
      bus.rsp_data   = 32'h77;
      #1;
      reset = 1'b1;
      #1;
      check_reset_values("mid-stream reset");
      bus.rsp_valid = 1'b0;
      step();
      reset          = 1'b0;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      step();
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h99;
      @(negedge clk);
      check("late rsp rsp_ready", bus.rsp_ready, 1);
      check("late rsp out0_valid", bus.out0_valid, 0);
      check("late rsp out1_valid", bus.out1_valid, 0);
      step();
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      check("late rsp raises orphan", bus.err_orphan, 1);

      repeat (3) step();
      check("out0 scoreboard empty", exp0.size(), 0);
      check("out1 scoreboard empty", exp1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
